// File: rtl/rgb2luma_pipe.sv
// RGB to luma converter: three-stage elastic pipeline (multiply, sum, round/saturate).
// Coefficients are selected per pixel at accept time and travel with the pixel as products.
// Every stage keeps its own valid bit. A stage loads when it is empty or when its contents
// move on, so bubbles collapse and the pipeline sustains one pixel per cycle.
module rgb2luma_pipe #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned coef_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      red_i,
  input  logic [width_p-1:0]      green_i,
  input  logic [width_p-1:0]      blue_i,
  input  logic [1:0]              mode_i,
  input  logic [coef_width_p-1:0] coef_r_i,
  input  logic [coef_width_p-1:0] coef_g_i,
  input  logic [coef_width_p-1:0] coef_b_i,
  input  logic                    last_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [width_p-1:0]      gray_o,
  output logic                    last_o,
  output logic                    sat_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int unsigned ProdW = width_p + coef_width_p;
  localparam int unsigned SumW  = ProdW + 2;

  // Rescale a 16-bit fractional constant to coef_width_p fractional bits.
  function automatic logic [coef_width_p-1:0] scale_coef(input logic [15:0] c);
    logic [coef_width_p+15:0] w;
    w = {{coef_width_p{1'b0}}, c};
    if (coef_width_p >= 16) begin
      w = w << (coef_width_p - 16);
    end else begin
      w = w >> (16 - coef_width_p);
    end
    return w[coef_width_p-1:0];
  endfunction

  localparam logic [coef_width_p-1:0] C601R = scale_coef(16'd19595);
  localparam logic [coef_width_p-1:0] C601G = scale_coef(16'd38470);
  localparam logic [coef_width_p-1:0] C601B = scale_coef(16'd7471);
  localparam logic [coef_width_p-1:0] C709R = scale_coef(16'd13933);
  localparam logic [coef_width_p-1:0] C709G = scale_coef(16'd46871);
  localparam logic [coef_width_p-1:0] C709B = scale_coef(16'd4732);
  localparam logic [coef_width_p-1:0] CAvgR = scale_coef(16'd21845);
  localparam logic [coef_width_p-1:0] CAvgG = scale_coef(16'd21846);
  localparam logic [coef_width_p-1:0] CAvgB = scale_coef(16'd21845);

  // Half an LSB of the output, added before truncation for round-half-up.
  localparam logic [SumW-1:0] RoundHalf = SumW'(1) << (coef_width_p - 1);

  // Stage state
  logic                    r_s1_valid;
  logic [ProdW-1:0]        r_s1_prod_r;
  logic [ProdW-1:0]        r_s1_prod_g;
  logic [ProdW-1:0]        r_s1_prod_b;
  logic                    r_s1_last;

  logic                    r_s2_valid;
  logic [SumW-1:0]         r_s2_sum;
  logic                    r_s2_last;

  logic                    r_s3_valid;
  logic [width_p-1:0]      r_s3_gray;
  logic                    r_s3_sat;
  logic                    r_s3_last;

  // Combinational helpers
  logic                    w_s1_en;
  logic                    w_s2_en;
  logic                    w_s3_en;
  logic                    w_accept;
  logic [coef_width_p-1:0] w_coef_r;
  logic [coef_width_p-1:0] w_coef_g;
  logic [coef_width_p-1:0] w_coef_b;
  logic [ProdW-1:0]        w_prod_r;
  logic [ProdW-1:0]        w_prod_g;
  logic [ProdW-1:0]        w_prod_b;
  logic [SumW-1:0]         w_sum;
  logic [SumW-1:0]         w_round;
  logic [SumW-1:0]         w_y;
  logic                    w_sat;
  logic [width_p-1:0]      w_gray;

  // Load enables: a stage loads when empty or when its current content moves on.
  always_comb begin
    w_s3_en  = !r_s3_valid || ready_i;
    w_s2_en  = !r_s2_valid || w_s3_en;
    w_s1_en  = !r_s1_valid || w_s2_en;
    ready_o  = w_s1_en && !reset_i;
    w_accept = valid_i && ready_o;
  end

  // Coefficient selection for the pixel being accepted.
  always_comb begin
    w_coef_r = C601R;
    w_coef_g = C601G;
    w_coef_b = C601B;
    unique case (mode_i)
      2'd0: begin
        w_coef_r = C601R;
        w_coef_g = C601G;
        w_coef_b = C601B;
      end
      2'd1: begin
        w_coef_r = C709R;
        w_coef_g = C709G;
        w_coef_b = C709B;
      end
      2'd2: begin
        w_coef_r = CAvgR;
        w_coef_g = CAvgG;
        w_coef_b = CAvgB;
      end
      2'd3: begin
        w_coef_r = coef_r_i;
        w_coef_g = coef_g_i;
        w_coef_b = coef_b_i;
      end
      default: ;
    endcase
  end

  // S1 datapath: per-channel products.
  always_comb begin
    w_prod_r = ProdW'(red_i) * ProdW'(w_coef_r);
    w_prod_g = ProdW'(green_i) * ProdW'(w_coef_g);
    w_prod_b = ProdW'(blue_i) * ProdW'(w_coef_b);
  end

  // S2 datapath: sum of products, two guard bits so it cannot overflow.
  always_comb begin
    w_sum = SumW'(r_s1_prod_r) + SumW'(r_s1_prod_g) + SumW'(r_s1_prod_b);
  end

  // S3 datapath: round half up, drop fraction, clip to the output range.
  always_comb begin
    w_round = r_s2_sum + RoundHalf;
    w_y     = w_round >> coef_width_p;
    w_sat   = |w_y[SumW-1:width_p];
    w_gray  = w_sat ? {width_p{1'b1}} : w_y[width_p-1:0];
  end

  // S1 register: valid bit resets, products and marker are unreset data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= w_accept;
    end
    if (w_s1_en) begin
      r_s1_prod_r <= w_prod_r;
      r_s1_prod_g <= w_prod_g;
      r_s1_prod_b <= w_prod_b;
      r_s1_last   <= last_i;
    end
  end

  // S2 register: takes whatever S1 holds when allowed to load.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
    end
    if (w_s2_en) begin
      r_s2_sum  <= w_sum;
      r_s2_last <= r_s1_last;
    end
  end

  // S3 register: output stage, fully reset so outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s3_valid <= 1'b0;
      r_s3_gray  <= '0;
      r_s3_sat   <= 1'b0;
      r_s3_last  <= 1'b0;
    end else if (w_s3_en) begin
      r_s3_valid <= r_s2_valid;
      r_s3_gray  <= w_gray;
      r_s3_sat   <= w_sat;
      r_s3_last  <= r_s2_last;
    end
  end

  // Outputs come straight from the S3 register, so they hold while stalled.
  always_comb begin
    valid_o = r_s3_valid;
    gray_o  = r_s3_gray;
    sat_o   = r_s3_sat;
    last_o  = r_s3_last;
  end

endmodule

// File: tb/tb_rgb2luma_pipe.sv
// Self-checking bench for rgb2luma_pipe: directed table, stall, burst, reset and random
// traffic, all deliveries compared against a scoreboard fed by a reference model.
module tb_rgb2luma_pipe;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  red_i, green_i, blue_i;
  logic [1:0]  mode_i;
  logic [15:0] coef_r_i, coef_g_i, coef_b_i;
  logic        last_i, valid_i, ready_o;
  logic [7:0]  gray_o;
  logic        last_o, sat_o, valid_o, ready_i;

  always #5 clk = ~clk;

  rgb2luma_pipe #(.width_p(8), .coef_width_p(16)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .red_i    (red_i),
    .green_i  (green_i),
    .blue_i   (blue_i),
    .mode_i   (mode_i),
    .coef_r_i (coef_r_i),
    .coef_g_i (coef_g_i),
    .coef_b_i (coef_b_i),
    .last_i   (last_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .gray_o   (gray_o),
    .last_o   (last_o),
    .sat_o    (sat_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  r, g, b;
    logic [15:0] cr, cg, cb;
    logic [7:0]  gray;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [7:0] gray;
    logic       sat;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_in   = 0;
  int   n_out  = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: y = (sum + 2^15) >> 16, clipped to 255.
  function automatic exp_t model(input logic [1:0] m, input logic [7:0] r, g, b,
                                 input logic [15:0] cr, cg, cb, input logic lst);
    exp_t   e;
    longint kr, kg, kb, s, y;
    case (m)
      2'd0:    begin kr = 19595; kg = 38470; kb = 7471;  end
      2'd1:    begin kr = 13933; kg = 46871; kb = 4732;  end
      2'd2:    begin kr = 21845; kg = 21846; kb = 21845; end
      default: begin kr = cr;    kg = cg;    kb = cb;    end
    endcase
    s = kr * r + kg * g + kb * b;
    y = (s + 32768) >> 16;
    e.sat  = (y > 255);
    e.gray = e.sat ? 8'd255 : y[7:0];
    e.last = lst;
    return e;
  endfunction

  // Monitor: push on accept, pop/compare on delivery, check hold while stalled.
  logic       hold_valid = 1'b0;
  logic [10:0] hold_val;
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      sb_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) chk("stall_hold", {valid_o, gray_o, last_o, sat_o}, hold_val);
      hold_valid = valid_o && !ready_i;
      hold_val   = {valid_o, gray_o, last_o, sat_o};
      if (valid_o && ready_i) begin
        n_out++;
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", {gray_o, sat_o, last_o}, {e.gray, e.sat, e.last});
        end
      end
      if (valid_i && ready_o) begin
        n_in++;
        sb_q.push_back(model(mode_i, red_i, green_i, blue_i, coef_r_i, coef_g_i, coef_b_i,
                             last_i));
      end
    end
  end

  task automatic drive_pix(input int k, input logic lst);
    red_i    = 8'(k * 10 + 1);
    green_i  = 8'(k * 20 + 3);
    blue_i   = 8'(k * 5);
    mode_i   = 2'(k % 3);
    coef_r_i = 16'd0;
    coef_g_i = 16'd0;
    coef_b_i = 16'd0;
    last_i   = lst;
  endtask

  vec_t vecs[8];

  initial begin
    logic        v1, v2, v3, acc, b2b, all_rdy, seen;
    logic [24:0] vo, lo, exp_vo;
    int          n_acc, n0, k, t, in0, out0;

    vecs[0] = '{2'd0, 8'd255, 8'd255, 8'd255, 16'd0, 16'd0, 16'd0, 8'd255, 1'b0};
    vecs[1] = '{2'd0, 8'd100, 8'd150, 8'd200, 16'd0, 16'd0, 16'd0, 8'd141, 1'b0};
    vecs[2] = '{2'd1, 8'd255, 8'd0,   8'd0,   16'd0, 16'd0, 16'd0, 8'd54,  1'b0};
    vecs[3] = '{2'd3, 8'd255, 8'd255, 8'd255, 16'd65535, 16'd65535, 16'd65535, 8'd255, 1'b1};
    vecs[4] = '{2'd2, 8'd0,   8'd0,   8'd0,   16'd0, 16'd0, 16'd0, 8'd0,   1'b0};
    vecs[5] = '{2'd2, 8'd30,  8'd60,  8'd90,  16'd0, 16'd0, 16'd0, 8'd60,  1'b0};
    vecs[6] = '{2'd3, 8'd200, 8'd0,   8'd0,   16'd32768, 16'd0, 16'd0, 8'd100, 1'b0};
    vecs[7] = '{2'd3, 8'd200, 8'd100, 8'd0,   16'd65535, 16'd65535, 16'd0, 8'd255, 1'b1};

    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    drive_pix(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_outs", {valid_o, gray_o, last_o, sat_o}, 0);
    reset_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_outs", {valid_o, gray_o, last_o, sat_o}, 0);

    // Table: pixel presented in cycle 0 must appear in cycle 3.
    foreach (vecs[i]) begin
      mode_i = vecs[i].mode; red_i = vecs[i].r; green_i = vecs[i].g; blue_i = vecs[i].b;
      coef_r_i = vecs[i].cr; coef_g_i = vecs[i].cg; coef_b_i = vecs[i].cb;
      last_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
      @(posedge clk); #1; valid_i = 1'b0; v1 = valid_o;
      @(posedge clk); #1; v2 = valid_o;
      @(posedge clk); #1; v3 = valid_o;
      chk($sformatf("latency[%0d]", i), {v1, v2, v3}, 3'b001);
      chk($sformatf("gray[%0d]", i), gray_o, vecs[i].gray);
      chk($sformatf("sat[%0d]", i), sat_o, vecs[i].sat);
      @(posedge clk); #1;
    end

    // Stall: downstream blocked, upstream keeps offering.
    ready_i = 1'b0; valid_i = 1'b1; k = 0; n_acc = 0;
    drive_pix(k, 1'b0);
    for (int i = 0; i < 10; i++) begin
      acc = ready_o;
      @(posedge clk); #1;
      if (acc) begin n_acc++; k++; drive_pix(k, 1'b0); end
    end
    chk("stall_accepts", n_acc, 3);
    chk("stall_ready_low", ready_o, 0);
    chk("stall_valid_o", valid_o, 1);
    valid_i = 1'b0; ready_i = 1'b1; n0 = n_out; b2b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b2b &= valid_o;
      @(posedge clk); #1;
    end
    chk("stall_b2b", b2b, 1);
    chk("stall_drained", n_out - n0, 3);
    chk("stall_empty", valid_o, 0);

    // Burst of 20 with last on the 20th.
    ready_i = 1'b1; all_rdy = 1'b1; exp_vo = '0;
    for (int i = 2; i < 22; i++) exp_vo[i] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i < 20) begin
        valid_i = 1'b1; drive_pix(100 + i, i == 19); all_rdy &= ready_o;
      end else begin
        valid_i = 1'b0; last_i = 1'b0;
      end
      @(posedge clk); #1;
      vo[i] = valid_o; lo[i] = last_o && valid_o;
    end
    chk("burst_ready", all_rdy, 1);
    chk("burst_valid_pattern", vo, exp_vo);
    chk("burst_last_pattern", lo, 25'd1 << 21);

    // Reset with two pixels in flight.
    valid_i = 1'b1; drive_pix(7, 1'b0);
    @(posedge clk); #1; drive_pix(8, 1'b1);
    @(posedge clk); #1; valid_i = 1'b0; reset_i = 1'b1;
    #1;
    chk("midrst_ready", ready_o, 0);
    @(posedge clk); #1;
    chk("midrst_valid_o", valid_o, 0);
    reset_i = 1'b0; #1;
    chk("midrst_ready_after", ready_o, 1);
    n0 = n_out; seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= valid_o; end
    chk("midrst_no_stale", seen, 0);
    valid_i = 1'b1; drive_pix(9, 1'b0);
    @(posedge clk); #1; valid_i = 1'b0;
    t = 0;
    while (n_out == n0 && t < 10) begin @(posedge clk); #1; t++; end
    chk("midrst_new_pixel", n_out - n0, 1);

    // Random traffic with per-pixel mode and coefficient changes.
    in0 = n_in; out0 = n_out;
    for (int i = 0; i < 500; i++) begin
      valid_i  = ($urandom_range(0, 99) < 60);
      ready_i  = ($urandom_range(0, 3) != 0);
      red_i    = 8'($urandom); green_i = 8'($urandom); blue_i = 8'($urandom);
      mode_i   = 2'($urandom);
      coef_r_i = 16'($urandom); coef_g_i = 16'($urandom); coef_b_i = 16'($urandom);
      last_i   = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1; t = 0;
    while (sb_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    chk("rand_drained", sb_q.size(), 0);
    chk("rand_in_out", n_out - out0, n_in - in0);
    chk("rand_idle", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
